// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEN   = 3'd1,
      DATA  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4,
      ERROR = 3'd5
   } state_e;

   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = 4;
   localparam int ADDR_STEP      = 4;

endpackage

// File: rtl/byte_assembler.sv
// Packs four little-endian stream bytes into one 32-bit word; used for both
// the length header and the instruction words.
module byte_assembler
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load,
   input  logic [7:0]        byte_in,
   output logic [WORD_W-1:0] word,
   output logic              word_complete
);

   logic [1:0]        idx_q;
   logic [WORD_W-1:0] shreg_q;

   // Bytes shift in from the top, so the first byte ends up in bits [7:0].
   assign word          = {byte_in, shreg_q[WORD_W-1:8]};
   assign word_complete = load && (idx_q == 2'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         idx_q   <= '0;
         shreg_q <= '0;
      end else if (load) begin
         idx_q   <= idx_q + 2'd1;
         shreg_q <= word;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a word-count header, writes the image into the
// instruction memory and keeps the processor in reset until it is complete.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_wr,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        err,
   output logic [31:0] words_written,
   output logic [2:0]  dbg_state
);

   // Handshake: a byte moves on a rising edge where in_valid && in_ready;
   // in_ready depends only on the registered state, never on in_valid.

   state_e      state_q, state_d;
   logic        in_ready_q, mem_wr_q, cpu_hold_q, done_q, err_q;
   logic [31:0] waddr_q, wdata_q, ww_q, rem_q;

   logic              xfer, start_ok, word_complete;
   logic [WORD_W-1:0] asm_word;

   assign xfer     = in_valid && in_ready_q;
   assign start_ok = start && (state_q == IDLE || state_q == DONE || state_q == ERROR);

   byte_assembler u_asm (
      .clk           (clk),
      .rst           (rst),
      .clr           (start_ok),
      .load          (xfer),
      .byte_in       (in_data),
      .word          (asm_word),
      .word_complete (word_complete)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERROR: if (start) state_d = LEN;
         LEN: begin
            if (word_complete) begin
               if (asm_word == '0)                   state_d = DONE;
               else if (asm_word > 32'(MAX_WORDS))   state_d = ERROR;
               else                                  state_d = DATA;
            end
         end
         DATA:    if (word_complete) state_d = WRITE;
         WRITE:   state_d = (rem_q == 32'd1) ? DONE : DATA;
         default: state_d = IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they change
   // together with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b0;
         mem_wr_q   <= 1'b0;
         cpu_hold_q <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         waddr_q    <= BASE_ADDR;
         wdata_q    <= '0;
         ww_q       <= '0;
         rem_q      <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d == LEN) || (state_d == DATA);
         mem_wr_q   <= (state_d == WRITE);
         cpu_hold_q <= (state_d != DONE);
         done_q     <= (state_d == DONE);
         err_q      <= (state_d == ERROR);
         if (start_ok) begin
            waddr_q <= BASE_ADDR;
            ww_q    <= '0;
         end
         if (state_q == LEN && word_complete) rem_q <= asm_word;
         if (state_q == DATA && word_complete) wdata_q <= asm_word;
         if (state_q == WRITE) begin
            waddr_q <= waddr_q + 32'(ADDR_STEP);
            ww_q    <= ww_q + 32'd1;
            rem_q   <= rem_q - 32'd1;
         end
      end
   end

   assign in_ready      = in_ready_q;
   assign mem_wr        = mem_wr_q;
   assign mem_waddr     = waddr_q;
   assign mem_wdata     = wdata_q;
   assign cpu_hold      = cpu_hold_q;
   assign done          = done_q;
   assign err           = err_q;
   assign words_written = ww_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes are queued by the
// stimulus and checked by an independent write monitor.
module tb_imem_loader;
   import imem_loader_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, mem_wr, cpu_hold, done, err;
   logic [31:0] mem_waddr, mem_wdata, words_written;
   logic [2:0]  dbg_state;

   int vectors = 0;
   int miscompares = 0;
   int writes_seen = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   imem_loader dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .mem_wr        (mem_wr),
      .mem_waddr     (mem_waddr),
      .mem_wdata     (mem_wdata),
      .cpu_hold      (cpu_hold),
      .done          (done),
      .err           (err),
      .words_written (words_written),
      .dbg_state     (dbg_state)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Write monitor: every write strobe must match the head of the queue.
   always @(negedge clk) begin
      if (mem_wr === 1'b1) begin
         writes_seen++;
         check("in_ready_in_write", 64'(in_ready), 64'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_write", {mem_waddr, mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("write_addr", 64'(mem_waddr), 64'(e[63:32]));
            check("write_data", 64'(mem_wdata), 64'(e[31:0]));
         end
      end
   end

   // All driver tasks start and end just after a falling edge.
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("in_ready_timeout", 64'd0, 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
   endtask

   task automatic two_word_image(input int gap);
      exp_q.push_back({32'h0000_0000, 32'h0010_0513});
      exp_q.push_back({32'h0000_0004, 32'h0020_0593});
      send_word(32'd2, gap);
      send_word(32'h0010_0513, gap);
      send_word(32'h0020_0593, gap);
   endtask

   task automatic check_done(input string tag, input int exp_words, input int exp_writes);
      repeat (2) @(negedge clk);
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_err"}, 64'(err), 64'd0);
      check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
      check({tag, "_words"}, 64'(words_written), 64'(exp_words));
      check({tag, "_writes"}, 64'(writes_seen), 64'(exp_writes));
      check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_state", 64'(dbg_state), 64'(IDLE));
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_mem_wr", 64'(mem_wr), 64'd0);
      check("rst_waddr", 64'(mem_waddr), 64'd0);
      check("rst_wdata", 64'(mem_wdata), 64'd0);
      check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_words", 64'(words_written), 64'd0);

      // Two-word image, stream always valid.
      pulse_start();
      two_word_image(0);
      check_done("two_word", 2, 2);

      // Zero-length header.
      pulse_start();
      send_word(32'd0, 0);
      check_done("zero_len", 0, 2);

      // Oversize header, then recovery with a one-word image.
      pulse_start();
      send_word(32'd1025, 0);
      repeat (2) @(negedge clk);
      check("oversize_err", 64'(err), 64'd1);
      check("oversize_cpu_hold", 64'(cpu_hold), 64'd1);
      check("oversize_in_ready", 64'(in_ready), 64'd0);
      check("oversize_done", 64'(done), 64'd0);
      check("oversize_writes", 64'(writes_seen), 64'd2);
      pulse_start();
      exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
      send_word(32'd1, 0);
      send_word(32'hDEAD_BEEF, 0);
      check_done("recover", 1, 3);

      // Back-pressure: three idle cycles before every byte.
      pulse_start();
      two_word_image(3);
      check_done("backpressure", 2, 5);

      // Reset one cycle after the sixth byte, then a clean reload.
      pulse_start();
      send_word(32'd2, 0);
      send_byte(8'h13, 0);
      send_byte(8'h05, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_state", 64'(dbg_state), 64'(IDLE));
      check("midrst_cpu_hold", 64'(cpu_hold), 64'd1);
      check("midrst_mem_wr", 64'(mem_wr), 64'd0);
      check("midrst_words", 64'(words_written), 64'd0);
      check("midrst_waddr", 64'(mem_waddr), 64'd0);
      pulse_start();
      two_word_image(0);
      check_done("after_rst", 2, 7);

      // Start during DATA is ignored; start after DONE reloads from base.
      pulse_start();
      exp_q.push_back({32'h0000_0000, 32'h1111_2222});
      exp_q.push_back({32'h0000_0004, 32'h3333_4444});
      send_word(32'd2, 0);
      send_word(32'h1111_2222, 0);
      @(negedge clk);
      pulse_start();
      check("ign_start_state", 64'(dbg_state), 64'(DATA));
      check("ign_start_words", 64'(words_written), 64'd1);
      send_word(32'h3333_4444, 0);
      check_done("ign_start", 2, 9);
      pulse_start();
      check("reload_cpu_hold", 64'(cpu_hold), 64'd1);
      check("reload_state", 64'(dbg_state), 64'(LEN));
      check("reload_words", 64'(words_written), 64'd0);
      exp_q.push_back({32'h0000_0000, 32'h0000_0013});
      send_word(32'd1, 0);
      send_word(32'h0000_0013, 0);
      check_done("reload", 1, 10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
